// File: rtl/layer_stream_ctrl.sv
// Captures an NN-wide upstream layer vector and replays it as a serial x_valid/x_in stream.
// Define LAYER_ARGMAX_EN to add a signed argmax over each streamed vector.
//
// state  | meaning
// S_IDLE | collecting per-neuron results into the buffer, pending mask tracks arrivals
// S_SEND | streaming buf[0..NN-1] one element per non-held cycle
module layer_stream_ctrl #(
    parameter int NN        = 30,
    parameter int dataWidth = 16,
    parameter int IDXW      = (NN > 1) ? $clog2(NN) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NN-1:0]           i_valid,
    input  logic [NN*dataWidth-1:0] i_data,
    input  logic                    hold,
    output logic                    x_valid,
    output logic [dataWidth-1:0]    x_in,
    output logic [IDXW-1:0]         x_idx,
    output logic                    busy,
    output logic                    layer_done,
    output logic                    overrun,
    output logic [IDXW-1:0]         argmax_idx,
    output logic                    argmax_valid
);

    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NN - 1);

    state_t                 state_q, state_d;
    logic [NN-1:0]          pending_q, pending_d;
    logic [dataWidth-1:0]   buf_q [NN];
    logic                   x_valid_q, x_valid_d;
    logic [dataWidth-1:0]   x_in_q, x_in_d;
    logic [IDXW-1:0]        x_idx_q, x_idx_d;
    logic                   busy_q, busy_d;
    logic                   layer_done_q, layer_done_d;
    logic                   overrun_q, overrun_d;
    logic [NN-1:0]          cap;
    logic [IDXW-1:0]        nxt_idx;
    logic                   start, emit, finish;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        cap       = '0;
        start     = 1'b0;
        emit      = 1'b0;
        finish    = 1'b0;
        nxt_idx   = x_idx_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                cap       = i_valid & ~pending_q;
                pending_d = pending_q | cap;
                if (|(i_valid & pending_q)) overrun_d = 1'b1;
                if (&pending_d) begin
                    start   = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // No double buffering: anything arriving while streaming is lost.
                if (|i_valid) overrun_d = 1'b1;
                if (x_idx_q == LAST_IDX) begin
                    finish    = 1'b1;
                    state_d   = S_IDLE;
                    pending_d = '0;
                end else if (!hold) begin
                    emit = 1'b1;
                end
            end
        endcase

        x_valid_d    = start | emit;
        busy_d       = (state_d == S_SEND);
        layer_done_d = finish;
        x_idx_d      = x_idx_q;
        x_in_d       = x_in_q;
        if (start) begin
            // Element 0 may be arriving on this very edge, so bypass the buffer.
            x_idx_d = '0;
            x_in_d  = cap[0] ? i_data[dataWidth-1:0] : buf_q[0];
        end else if (emit) begin
            x_idx_d = nxt_idx;
            x_in_d  = buf_q[nxt_idx];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            x_valid_q    <= 1'b0;
            x_in_q       <= '0;
            x_idx_q      <= '0;
            busy_q       <= 1'b0;
            layer_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            x_valid_q    <= x_valid_d;
            x_in_q       <= x_in_d;
            x_idx_q      <= x_idx_d;
            busy_q       <= busy_d;
            layer_done_q <= layer_done_d;
            overrun_q    <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NN; i++) begin
            if (cap[i]) buf_q[i] <= i_data[i*dataWidth +: dataWidth];
        end
    end

    assign x_valid    = x_valid_q;
    assign x_in       = x_in_q;
    assign x_idx      = x_idx_q;
    assign busy       = busy_q;
    assign layer_done = layer_done_q;
    assign overrun    = overrun_q;

`ifdef LAYER_ARGMAX_EN
    logic signed [dataWidth-1:0] max_q;
    logic [IDXW-1:0]             max_idx_q;
    logic [IDXW-1:0]             argmax_idx_q;
    logic                        argmax_valid_q;

    // Strict greater-than so ties keep the lowest index.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            max_q          <= '0;
            max_idx_q      <= '0;
            argmax_idx_q   <= '0;
            argmax_valid_q <= 1'b0;
        end else begin
            argmax_valid_q <= finish;
            if (finish) argmax_idx_q <= max_idx_q;
            if (start) begin
                max_q     <= x_in_d;
                max_idx_q <= '0;
            end else if (emit && ($signed(x_in_d) > max_q)) begin
                max_q     <= x_in_d;
                max_idx_q <= x_idx_d;
            end
        end
    end

    assign argmax_idx   = argmax_idx_q;
    assign argmax_valid = argmax_valid_q;
`else
    assign argmax_idx   = '0;
    assign argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_stream_ctrl.sv
// Bench for layer_stream_ctrl (NN=4, 16-bit): directed scenarios plus a randomized run
// against a queue-based transaction model.
module tb_layer_stream_ctrl;

    localparam int NN = 4;
    localparam int DW = 16;
    localparam int IW = 2;
`ifdef LAYER_ARGMAX_EN
    localparam bit AM_EN = 1'b1;
`else
    localparam bit AM_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [NN-1:0]    i_valid = '0;
    logic [NN*DW-1:0] i_data = '0;
    logic             hold = 1'b0;
    logic             x_valid;
    logic [DW-1:0]    x_in;
    logic [IW-1:0]    x_idx;
    logic             busy;
    logic             layer_done;
    logic             overrun;
    logic [IW-1:0]    argmax_idx;
    logic             argmax_valid;

    int n_cmp = 0;
    int n_err = 0;

    layer_stream_ctrl #(.NN(NN), .dataWidth(DW)) dut (
        .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_data(i_data), .hold(hold),
        .x_valid(x_valid), .x_in(x_in), .x_idx(x_idx), .busy(busy),
        .layer_done(layer_done), .overrun(overrun),
        .argmax_idx(argmax_idx), .argmax_valid(argmax_valid)
    );

    always #5 clk = ~clk;

    // Transaction model: a pending set, a captured vector, and a queue of elements still to send.
    logic [DW-1:0] m_buf [NN];
    logic [NN-1:0] m_pend;
    bit            m_send;
    logic [DW-1:0] q_val[$];
    int            q_idx[$];
    int            m_am;
    bit            e_xv, e_busy, e_done, e_ovr, e_amv;
    logic [DW-1:0] e_xin;
    logic [IW-1:0] e_xidx, e_ami;

    task automatic model_reset();
        m_pend = '0; m_send = 0; q_val.delete(); q_idx.delete(); m_am = 0;
        e_xv = 0; e_busy = 0; e_done = 0; e_ovr = 0; e_amv = 0;
        e_xin = '0; e_xidx = '0; e_ami = '0;
    endtask

    task automatic model_edge();
        e_xv = 0; e_done = 0; e_amv = 0;
        if (!m_send) begin
            for (int i = 0; i < NN; i++) begin
                if (i_valid[i]) begin
                    if (m_pend[i]) e_ovr = 1;
                    else begin
                        m_buf[i]  = i_data[i*DW +: DW];
                        m_pend[i] = 1'b1;
                    end
                end
            end
            if (&m_pend) begin
                m_send = 1; e_busy = 1; m_am = 0;
                q_val.delete(); q_idx.delete();
                for (int i = 0; i < NN; i++) begin
                    q_val.push_back(m_buf[i]);
                    q_idx.push_back(i);
                    if ($signed(m_buf[i]) > $signed(m_buf[m_am])) m_am = i;
                end
                e_xv = 1; e_xin = q_val.pop_front(); e_xidx = IW'(q_idx.pop_front());
            end
        end else begin
            if (|i_valid) e_ovr = 1;
            if (q_val.size() == 0) begin
                m_send = 0; m_pend = '0; e_busy = 0; e_done = 1;
                if (AM_EN) begin e_amv = 1; e_ami = IW'(m_am); end
            end else if (!hold) begin
                e_xv = 1; e_xin = q_val.pop_front(); e_xidx = IW'(q_idx.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; i_valid = '0; hold = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (x_valid !== 1'b0) begin n_err++; $display("FAIL reset_x_valid got=%0b exp=0", x_valid); end
        n_cmp++; if (x_in !== '0) begin n_err++; $display("FAIL reset_x_in got=%0h exp=0", x_in); end
        n_cmp++; if (x_idx !== '0) begin n_err++; $display("FAIL reset_x_idx got=%0d exp=0", x_idx); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_cmp++; if (layer_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%0b exp=0", layer_done); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        n_cmp++; if (argmax_idx !== '0) begin n_err++; $display("FAIL reset_am_idx got=%0d exp=0", argmax_idx); end
        n_cmp++; if (argmax_valid !== 1'b0) begin n_err++; $display("FAIL reset_am_valid got=%0b exp=0", argmax_valid); end
    endtask

    task automatic test_simultaneous();
        i_valid = 4'hF; i_data = {16'h0004, 16'h0003, 16'h0002, 16'h0001}; hold = 0;
        tick();
        i_valid = '0;
        for (int k = 0; k < NN; k++) begin
            n_cmp++; if (x_valid !== 1'b1) begin n_err++; $display("FAIL simul_xv k=%0d got=%0b exp=1", k, x_valid); end
            n_cmp++; if (x_in !== DW'(k + 1)) begin n_err++; $display("FAIL simul_x_in k=%0d got=%0h exp=%0h", k, x_in, k + 1); end
            n_cmp++; if (x_idx !== IW'(k)) begin n_err++; $display("FAIL simul_x_idx k=%0d got=%0d exp=%0d", k, x_idx, k); end
            n_cmp++; if (busy !== 1'b1 || layer_done !== 1'b0) begin n_err++; $display("FAIL simul_busy k=%0d got=%0b/%0b exp=1/0", k, busy, layer_done); end
            tick();
        end
        n_cmp++; if (layer_done !== 1'b1 || busy !== 1'b0 || x_valid !== 1'b0) begin n_err++; $display("FAIL simul_done got=%0b/%0b/%0b exp=1/0/0", layer_done, busy, x_valid); end
        tick();
        n_cmp++; if (layer_done !== 1'b0) begin n_err++; $display("FAIL simul_done_pulse got=%0b exp=0", layer_done); end
    endtask

    task automatic test_back_to_back();
        i_valid = 4'hF; i_data = {16'h0014, 16'h0013, 16'h0012, 16'h0011};
        tick();
        i_valid = '0;
        repeat (NN) tick();
        n_cmp++; if (layer_done !== 1'b1) begin n_err++; $display("FAIL b2b_done got=%0b exp=1", layer_done); end
        i_valid = 4'hF; i_data = {16'h0024, 16'h0023, 16'h0022, 16'h0021};
        tick();
        i_valid = '0;
        for (int k = 0; k < NN; k++) begin
            n_cmp++; if (x_valid !== 1'b1 || x_in !== DW'(16'h21 + k) || x_idx !== IW'(k)) begin
                n_err++; $display("FAIL b2b_elem k=%0d got=%0b/%0h/%0d exp=1/%0h/%0d", k, x_valid, x_in, x_idx, 16'h21 + k, k);
            end
            tick();
        end
        n_cmp++; if (overrun !== 1'b0 || layer_done !== 1'b1) begin n_err++; $display("FAIL b2b_end got=%0b/%0b exp=0/1", overrun, layer_done); end
        tick();
    endtask

    task automatic test_staggered();
        logic [NN-1:0] sched [6];
        sched = '{4'b0001, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b0100};
        i_data = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
        for (int e = 0; e < 6; e++) begin
            i_valid = sched[e];
            tick();
            if (e < 5) begin
                n_cmp++; if (x_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL stag_early e=%0d got=%0b/%0b exp=0/0", e, x_valid, busy); end
            end
        end
        i_valid = '0;
        for (int k = 0; k < NN; k++) begin
            n_cmp++; if (x_valid !== 1'b1 || x_in !== DW'(16'hA0 + k)) begin n_err++; $display("FAIL stag_elem k=%0d got=%0b/%0h exp=1/%0h", k, x_valid, x_in, 16'hA0 + k); end
            tick();
        end
        n_cmp++; if (layer_done !== 1'b1) begin n_err++; $display("FAIL stag_done got=%0b exp=1", layer_done); end
        tick();
    endtask

    task automatic test_hold();
        i_valid = 4'hF; i_data = {16'h0034, 16'h0033, 16'h0032, 16'h0031}; hold = 0;
        tick();
        i_valid = '0;
        n_cmp++; if (x_valid !== 1'b1 || x_in !== 16'h0031) begin n_err++; $display("FAIL hold_e0 got=%0b/%0h exp=1/31", x_valid, x_in); end
        tick();
        n_cmp++; if (x_valid !== 1'b1 || x_in !== 16'h0032 || x_idx !== 2'd1) begin n_err++; $display("FAIL hold_e1 got=%0b/%0h/%0d exp=1/32/1", x_valid, x_in, x_idx); end
        hold = 1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++; if (x_valid !== 1'b0 || x_idx !== 2'd1 || busy !== 1'b1) begin n_err++; $display("FAIL hold_stall c=%0d got=%0b/%0d/%0b exp=0/1/1", c, x_valid, x_idx, busy); end
        end
        hold = 0;
        tick();
        n_cmp++; if (x_valid !== 1'b1 || x_in !== 16'h0033 || x_idx !== 2'd2) begin n_err++; $display("FAIL hold_e2 got=%0b/%0h/%0d exp=1/33/2", x_valid, x_in, x_idx); end
        tick();
        n_cmp++; if (x_valid !== 1'b1 || x_in !== 16'h0034 || x_idx !== 2'd3) begin n_err++; $display("FAIL hold_e3 got=%0b/%0h/%0d exp=1/34/3", x_valid, x_in, x_idx); end
        tick();
        n_cmp++; if (layer_done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL hold_done got=%0b/%0b exp=1/0", layer_done, busy); end
        tick();
    endtask

    task automatic test_argmax();
        logic [NN*DW-1:0] vecs [3];
        logic [IW-1:0]    win  [3];
        vecs = '{{16'h0002, 16'h0005, 16'hFFFF, 16'h0005},
                 {16'h0003, 16'h0007, 16'h0007, 16'h0001},
                 {16'h0000, 16'h8000, 16'h0001, 16'hFFFF}};
        win  = '{2'd0, 2'd1, 2'd1};
        for (int v = 0; v < 3; v++) begin
            i_valid = 4'hF; i_data = vecs[v];
            tick();
            i_valid = '0;
            repeat (NN - 1) tick();
            n_cmp++; if (argmax_valid !== 1'b0) begin n_err++; $display("FAIL am_early v=%0d got=%0b exp=0", v, argmax_valid); end
            tick();
            n_cmp++; if (layer_done !== 1'b1 || argmax_valid !== AM_EN) begin n_err++; $display("FAIL am_valid v=%0d got=%0b/%0b exp=1/%0b", v, layer_done, argmax_valid, AM_EN); end
            n_cmp++; if (argmax_idx !== (AM_EN ? win[v] : 2'd0)) begin n_err++; $display("FAIL am_idx v=%0d got=%0d exp=%0d", v, argmax_idx, AM_EN ? win[v] : 2'd0); end
            tick();
            n_cmp++; if (argmax_valid !== 1'b0) begin n_err++; $display("FAIL am_pulse v=%0d got=%0b exp=0", v, argmax_valid); end
        end
    endtask

    task automatic test_random();
        int dones = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NN; i++) i_valid[i] = ($urandom_range(0, 3) == 0);
            i_data = {$urandom(), $urandom()};
            hold   = ($urandom_range(0, 2) == 0);
            tick();
            n_cmp++; if (x_valid !== e_xv) begin n_err++; $display("FAIL rnd_x_valid c=%0d got=%0b exp=%0b", c, x_valid, e_xv); end
            if (e_xv) begin
                n_cmp++; if (x_in !== e_xin || x_idx !== e_xidx) begin n_err++; $display("FAIL rnd_elem c=%0d got=%0h/%0d exp=%0h/%0d", c, x_in, x_idx, e_xin, e_xidx); end
            end
            n_cmp++; if (busy !== e_busy || layer_done !== e_done) begin n_err++; $display("FAIL rnd_ctl c=%0d got=%0b/%0b exp=%0b/%0b", c, busy, layer_done, e_busy, e_done); end
            n_cmp++; if (overrun !== e_ovr) begin n_err++; $display("FAIL rnd_overrun c=%0d got=%0b exp=%0b", c, overrun, e_ovr); end
            n_cmp++; if (argmax_valid !== e_amv || argmax_idx !== e_ami) begin n_err++; $display("FAIL rnd_argmax c=%0d got=%0b/%0d exp=%0b/%0d", c, argmax_valid, argmax_idx, e_amv, e_ami); end
            if (e_done) dones++;
        end
        n_cmp++; if (dones < 5) begin n_err++; $display("FAIL rnd_progress got=%0d exp=>=5 layers", dones); end
        i_valid = '0; hold = 0;
    endtask

    task automatic test_overrun();
        i_valid = 4'b0100; i_data = {16'h00D3, 16'h1111, 16'h00D1, 16'h00D0};
        tick();
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_first got=%0b exp=0", overrun); end
        i_data = {16'h00D3, 16'h2222, 16'h00D1, 16'h00D0};
        tick();
        n_cmp++; if (overrun !== 1'b1 || x_valid !== 1'b0) begin n_err++; $display("FAIL ovr_drop got=%0b/%0b exp=1/0", overrun, x_valid); end
        i_valid = 4'b1011; i_data = {16'h0033, 16'h3333, 16'h0011, 16'h0010};
        tick();
        n_cmp++; if (x_valid !== 1'b1 || x_in !== 16'h0010) begin n_err++; $display("FAIL ovr_e0 got=%0b/%0h exp=1/10", x_valid, x_in); end
        i_valid = 4'hF; i_data = {4{16'hEEEE}};
        tick();
        i_valid = '0;
        n_cmp++; if (x_in !== 16'h0011) begin n_err++; $display("FAIL ovr_e1 got=%0h exp=11", x_in); end
        tick();
        n_cmp++; if (x_in !== 16'h1111 || x_idx !== 2'd2) begin n_err++; $display("FAIL ovr_kept got=%0h/%0d exp=1111/2", x_in, x_idx); end
        tick();
        n_cmp++; if (x_in !== 16'h0033) begin n_err++; $display("FAIL ovr_e3 got=%0h exp=33", x_in); end
        tick();
        n_cmp++; if (layer_done !== 1'b1) begin n_err++; $display("FAIL ovr_done got=%0b exp=1", layer_done); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (overrun !== 1'b1 || x_valid !== 1'b0) begin n_err++; $display("FAIL ovr_sticky c=%0d got=%0b/%0b exp=1/0", c, overrun, x_valid); end
        end
    endtask

    task automatic test_async_reset();
        i_valid = 4'hF; i_data = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        tick();
        i_valid = '0;
        tick();
        tick();
        n_cmp++; if (x_in !== 16'h0030 || x_idx !== 2'd2) begin n_err++; $display("FAIL arst_pre got=%0h/%0d exp=30/2", x_in, x_idx); end
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if ({x_valid, busy, layer_done, overrun, argmax_valid} !== 5'b0) begin
            n_err++; $display("FAIL arst_ctl got=%0b%0b%0b%0b%0b exp=00000", x_valid, busy, layer_done, overrun, argmax_valid);
        end
        n_cmp++; if (x_in !== '0 || x_idx !== '0 || argmax_idx !== '0) begin n_err++; $display("FAIL arst_data got=%0h/%0d/%0d exp=0/0/0", x_in, x_idx, argmax_idx); end
        model_reset();
        @(posedge clk);
        #1 rstn = 1'b1;
        tick();
        n_cmp++; if (x_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL arst_mask got=%0b/%0b exp=0/0", x_valid, busy); end
        i_valid = 4'b0111; i_data = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
        tick();
        n_cmp++; if (x_valid !== 1'b0) begin n_err++; $display("FAIL arst_partial got=%0b exp=0", x_valid); end
        i_valid = 4'b1000;
        tick();
        i_valid = '0;
        for (int k = 0; k < NN; k++) begin
            n_cmp++; if (x_valid !== 1'b1 || x_in !== DW'(16'h0A + k) || x_idx !== IW'(k)) begin
                n_err++; $display("FAIL arst_elem k=%0d got=%0b/%0h/%0d exp=1/%0h/%0d", k, x_valid, x_in, x_idx, 16'h0A + k, k);
            end
            tick();
        end
        n_cmp++; if (layer_done !== 1'b1 || overrun !== 1'b0) begin n_err++; $display("FAIL arst_done got=%0b/%0b exp=1/0", layer_done, overrun); end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_back_to_back();
        test_staggered();
        test_hold();
        test_argmax();
        test_random();
        do_reset();
        test_overrun();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
